divide: RTL

Sequential radix-2 integer divider, the inverse companion to the team's sequential Booth multiplier in the arithmetic datapath. It accepts a dividend/divisor pair on a start pulse and iterates one quotient bit per clock. It then returns quotient, remainder and status flags with a one-cycle done pulse. Signed (two's complement, truncate toward zero) and unsigned modes are selectable per operation.

---
 rtl/divide_if.sv | 24 ++
 rtl/divide.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/divide_if.sv
// Operand/result bundle for the sequential divider. The requester drives the
// operands and start. The divider returns the results and status flags.
interface divide_if #(parameter int WIDTH = 16);
   logic             start;
   logic             signed_op;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic             overflow;

   modport master (
      output start, signed_op, dividend, divisor,
      input  quotient, remainder, busy, done, div_by_zero, overflow
   );

   modport slave (
      input  start, signed_op, dividend, divisor,
      output quotient, remainder, busy, done, div_by_zero, overflow
   );
endinterface

// File: rtl/divide.sv
// Sequential radix-2 restoring divider. It produces one quotient bit per clock
// and supports signed (truncating) and unsigned operation.
//
// state | meaning
// IDLE  | waiting for start; operands and signs captured on accept
// ITER  | WIDTH restoring steps on the operand magnitudes, MSB first
// FIX   | apply result signs and the divide-by-zero override
// DONE  | load output registers; done pulses on the following cycle
module divide #(
   parameter int WIDTH = 16
) (
   input  logic   clk,
   input  logic   rst,
   divide_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] raw_q, raw_d;
   logic             qsign_q, qsign_d;
   logic             rsign_q, rsign_d;
   logic             dz_q, dz_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             dz_out_q, dz_out_d;
   logic             ovf_out_q, ovf_out_d;

   logic [WIDTH:0]   r_sh;
   logic             neg_dvd;
   logic             neg_dvs;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      r_d         = r_q;
      dvd_d       = dvd_q;
      dvs_d       = dvs_q;
      quo_d       = quo_q;
      raw_d       = raw_q;
      qsign_d     = qsign_q;
      rsign_d     = rsign_q;
      dz_d        = dz_q;
      ovf_d       = ovf_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dz_out_d    = dz_out_q;
      ovf_out_d   = ovf_out_q;
      done_d      = 1'b0;
      r_sh        = '0;
      neg_dvd     = 1'b0;
      neg_dvs     = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               neg_dvd = bus.signed_op & bus.dividend[WIDTH-1];
               neg_dvs = bus.signed_op & bus.divisor[WIDTH-1];
               // Negating the most negative value yields 2^(WIDTH-1), which is
               // the correct unsigned magnitude.
               dvd_d   = neg_dvd ? -bus.dividend : bus.dividend;
               dvs_d   = neg_dvs ? -bus.divisor  : bus.divisor;
               qsign_d = neg_dvd ^ neg_dvs;
               rsign_d = neg_dvd;
               raw_d   = bus.dividend;
               dz_d    = (bus.divisor == '0);
               ovf_d   = bus.signed_op
                         & (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}})
                         & (bus.divisor == '1);
               r_d     = '0;
               quo_d   = '0;
               cnt_d   = CW'(WIDTH - 1);
               state_d = ITER;
            end
         end
         ITER: begin
            r_sh  = {r_q, dvd_q[WIDTH-1]};
            dvd_d = dvd_q << 1;
            if (r_sh >= {1'b0, dvs_q}) begin
               r_d   = WIDTH'(r_sh - {1'b0, dvs_q});
               quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
               r_d   = r_sh[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            if (cnt_q == '0) begin
               state_d = FIX;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         FIX: begin
            // The -2^(WIDTH-1) / -1 case wraps naturally here; only its flag
            // needs special handling.
            if (dz_q) begin
               quo_d = '1;
               r_d   = raw_q;
            end else begin
               quo_d = qsign_q ? -quo_q : quo_q;
               r_d   = rsign_q ? -r_q : r_q;
            end
            state_d = DONE;
         end
         DONE: begin
            quotient_d  = quo_q;
            remainder_d = r_q;
            dz_out_d    = dz_q;
            ovf_out_d   = ovf_q;
            done_d      = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         r_q         <= '0;
         dvd_q       <= '0;
         dvs_q       <= '0;
         quo_q       <= '0;
         raw_q       <= '0;
         qsign_q     <= 1'b0;
         rsign_q     <= 1'b0;
         dz_q        <= 1'b0;
         ovf_q       <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         dz_out_q    <= 1'b0;
         ovf_out_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         r_q         <= r_d;
         dvd_q       <= dvd_d;
         dvs_q       <= dvs_d;
         quo_q       <= quo_d;
         raw_q       <= raw_d;
         qsign_q     <= qsign_d;
         rsign_q     <= rsign_d;
         dz_q        <= dz_d;
         ovf_q       <= ovf_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         dz_out_q    <= dz_out_d;
         ovf_out_q   <= ovf_out_d;
      end
   end

   assign bus.quotient    = quotient_q;
   assign bus.remainder   = remainder_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.div_by_zero = dz_out_q;
   assign bus.overflow    = ovf_out_q;
endmodule
